// File: rtl/direction_queue.sv
// Turns synchronised one-hot key changes into legal turn requests, queues them, applies one per tick.
// Key-to-queue 3 edges, tick-to-direction 1 edge; no backpressure: a full queue drops the request and pulses o_dropped.
module direction_queue #(
  parameter int         DEPTH    = 2,
  parameter logic [3:0] INIT_DIR = 4'b1000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_mapped_key,
  input  logic       i_tick,
  input  logic       i_clear,
  output logic [3:0] o_direction,
  output logic       o_turned,
  output logic       o_dropped,
  output logic [2:0] o_queue_count
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  localparam logic [2:0] CAP  = 3'(DEPTH);

  logic [3:0] r_s1, r_s2, r_s3;
  logic [3:0] r_dir;
  logic       r_turned, r_dropped;
  logic [2:0] r_count;
  logic [1:0] r_rd_ptr, r_wr_ptr;
  logic [3:0] r_q [0:3];

  logic       w_onehot, w_event, w_legal, w_pop, w_space, w_push, w_drop;
  logic [1:0] w_tail_idx;
  logic [3:0] w_ref, w_opp;
  logic       w_unused_hi;

  assign w_unused_hi = ^i_mapped_key[7:4];

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_onehot   = (r_s2 != 4'd0) && ((r_s2 & (r_s2 - 4'd1)) == 4'd0);
  assign w_event    = w_onehot && (r_s2 != r_s3);
  // Filtering compares against the newest pending turn, not the live direction.
  assign w_tail_idx = (r_wr_ptr == 2'd0) ? LAST : r_wr_ptr - 2'd1;
  assign w_ref      = (r_count != 3'd0) ? r_q[w_tail_idx] : r_dir;
  assign w_opp      = {w_ref[2], w_ref[3], w_ref[0], w_ref[1]};
  assign w_legal    = w_event && (r_s2 != w_ref) && (r_s2 != w_opp);
  assign w_pop      = i_tick && (r_count != 3'd0);
  assign w_space    = (r_count < CAP) || w_pop;
  assign w_push     = w_legal && w_space;
  assign w_drop     = w_legal && !w_space;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1      <= 4'd0;
      r_s2      <= 4'd0;
      r_s3      <= 4'd0;
      r_dir     <= INIT_DIR;
      r_turned  <= 1'b0;
      r_dropped <= 1'b0;
      r_count   <= 3'd0;
      r_rd_ptr  <= 2'd0;
      r_wr_ptr  <= 2'd0;
    end else begin
      r_s1 <= i_mapped_key[3:0];
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (i_clear) begin
        r_dir     <= INIT_DIR;
        r_turned  <= 1'b0;
        r_dropped <= 1'b0;
        r_count   <= 3'd0;
        r_rd_ptr  <= 2'd0;
        r_wr_ptr  <= 2'd0;
      end else begin
        r_turned  <= w_pop;
        r_dropped <= w_drop;
        if (w_pop) begin
          r_dir    <= r_q[r_rd_ptr];
          r_rd_ptr <= nxt(r_rd_ptr);
        end
        if (w_push) begin
          r_q[r_wr_ptr] <= r_s2;
          r_wr_ptr      <= nxt(r_wr_ptr);
        end
        if (w_push && !w_pop)
          r_count <= r_count + 3'd1;
        else if (!w_push && w_pop)
          r_count <= r_count - 3'd1;
      end
    end
  end

  assign o_direction   = r_dir;
  assign o_turned      = r_turned;
  assign o_dropped     = r_dropped;
  assign o_queue_count = r_count;

endmodule

// File: tb/tb_direction_queue.sv
// Scoreboarded bench for direction_queue: directed scenarios followed by a random soak.
module tb_direction_queue;
  localparam int         DEPTH = 2;
  localparam logic [3:0] INIT  = 4'b1000;
  localparam logic [3:0] UP = 4'h1, DOWN = 4'h2, LEFT = 4'h4, RIGHT = 4'h8;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1, i_tick = 1'b0, i_clear = 1'b0;
  logic [7:0] i_mapped_key = 8'h00;
  logic [3:0] o_direction;
  logic       o_turned, o_dropped;
  logic [2:0] o_queue_count;

  always #5 clk = ~clk;

  direction_queue #(.DEPTH(DEPTH), .INIT_DIR(INIT)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_mapped_key(i_mapped_key),
    .i_tick(i_tick), .i_clear(i_clear), .o_direction(o_direction),
    .o_turned(o_turned), .o_dropped(o_dropped), .o_queue_count(o_queue_count)
  );

  int total = 0, bad = 0;
  int cyc = 0, drop_seen = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending turns as a plain list, keys seen two samples late.
  typedef struct { int stamp; logic [3:0] dir; } turn_t;
  turn_t      turn_q[$];
  int         drop_q[$];
  logic [3:0] mq[$];
  logic [3:0] dly[$] = '{4'h0, 4'h0};
  logic [3:0] last_seen = 4'h0;
  logic [3:0] mdl_dir = INIT;
  int         mdl_cnt = 0;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] cur, rf;
    bit ev, legal;
    cyc++;
    cur = dly[0];
    if (i_reset) begin
      dly = '{4'h0, 4'h0};
      last_seen = 4'h0;
      mq.delete();
      mdl_dir = INIT;
    end else begin
      ev = (cur != last_seen) && $onehot(cur);
      last_seen = cur;
      void'(dly.pop_front());
      dly.push_back(i_mapped_key[3:0]);
      if (i_clear) begin
        mq.delete();
        mdl_dir = INIT;
      end else begin
        rf = (mq.size() > 0) ? mq[$] : mdl_dir;
        legal = ev && (cur != rf) && (cur != opposite(rf));
        if (i_tick && mq.size() > 0) begin
          mdl_dir = mq.pop_front();
          turn_q.push_back('{cyc, mdl_dir});
        end
        if (legal) begin
          if (mq.size() < DEPTH) mq.push_back(cur);
          else drop_q.push_back(cyc);
        end
      end
    end
    mdl_cnt = mq.size();
  end

  // Monitor: consumes expected pulses when the DUT presents them.
  always @(negedge clk) begin
    bit    exp_t, exp_d;
    turn_t tr;
    int    ds;
    if (mon_en) begin
      exp_t = (turn_q.size() > 0) && (turn_q[0].stamp == cyc);
      chk("turned", int'(o_turned), int'(exp_t));
      if (turn_q.size() > 0 && turn_q[0].stamp <= cyc) begin
        tr = turn_q.pop_front();
        chk("turn_dir", int'(o_direction), int'(tr.dir));
      end
      exp_d = (drop_q.size() > 0) && (drop_q[0] == cyc);
      chk("dropped", int'(o_dropped), int'(exp_d));
      if (drop_q.size() > 0 && drop_q[0] <= cyc) ds = drop_q.pop_front();
      chk("count", int'(o_queue_count), mdl_cnt);
      chk("dir", int'(o_direction), int'(mdl_dir));
      if (o_dropped) drop_seen++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_tick();
    i_tick = 1'b1; @(negedge clk); i_tick = 1'b0;
  endtask
  task automatic pulse_clear();
    i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
  endtask
  task automatic pulse_reset();
    i_reset = 1'b1; @(negedge clk); i_reset = 1'b0;
  endtask
  task automatic load_up_left();
    i_mapped_key = 8'h00; wait_n(3);
    i_mapped_key = 8'h01; wait_n(3);
    i_mapped_key = 8'h04; wait_n(4);
  endtask

  logic [7:0] keys [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h05, 8'hF0, 8'h31};

  initial begin
    int d0, hold;
    wait_n(2);
    mon_en  = 1'b1;
    i_reset = 1'b0;
    chk("reset_dir", int'(o_direction), 8);
    chk("reset_cnt", int'(o_queue_count), 0);
    chk("reset_turned", int'(o_turned), 0);

    // First turn
    i_mapped_key = 8'h01; wait_n(4);
    chk("first_cnt", int'(o_queue_count), 1);
    pulse_tick();
    chk("first_dir", int'(o_direction), 1);
    chk("first_turned", int'(o_turned), 1);
    chk("first_cnt_after", int'(o_queue_count), 0);
    wait_n(1);
    chk("first_turned_once", int'(o_turned), 0);

    // Reversal and repeat are filtered
    pulse_clear();
    chk("clr_dir", int'(o_direction), 8);
    d0 = drop_seen;
    i_mapped_key = 8'h04; wait_n(4);
    chk("rev_cnt", int'(o_queue_count), 0);
    i_mapped_key = 8'h00; wait_n(3);
    i_mapped_key = 8'h08; wait_n(4);
    chk("rep_cnt", int'(o_queue_count), 0);
    chk("filt_nodrop", drop_seen - d0, 0);
    pulse_tick();
    chk("filt_dir", int'(o_direction), 8);
    chk("filt_turned", int'(o_turned), 0);

    // Fill and overflow
    i_mapped_key = 8'h00; wait_n(3);
    d0 = drop_seen;
    i_mapped_key = 8'h01; wait_n(3);
    i_mapped_key = 8'h04; wait_n(3);
    chk("fill_cnt", int'(o_queue_count), 2);
    i_mapped_key = 8'h02; wait_n(4);
    chk("full_cnt", int'(o_queue_count), 2);
    chk("full_drop", drop_seen - d0, 1);
    pulse_tick();
    chk("full_pop1", int'(o_direction), 1);
    pulse_tick();
    chk("full_pop2", int'(o_direction), 4);
    chk("full_empty", int'(o_queue_count), 0);

    // Tick coincides with accepted push while full
    pulse_clear();
    load_up_left();
    chk("sim_pre_cnt", int'(o_queue_count), 2);
    d0 = drop_seen;
    i_mapped_key = 8'h02; wait_n(2);
    pulse_tick();
    chk("sim_dir", int'(o_direction), 1);
    chk("sim_cnt", int'(o_queue_count), 2);
    pulse_tick();
    chk("sim_pop2", int'(o_direction), 4);
    pulse_tick();
    chk("sim_pop3", int'(o_direction), 2);
    chk("sim_nodrop", drop_seen - d0, 0);

    // Clear and reset mid-operation with LEFT held
    pulse_clear();
    load_up_left();
    chk("cr_pre_cnt", int'(o_queue_count), 2);
    pulse_clear();
    chk("clr_cnt", int'(o_queue_count), 0);
    chk("clr_dir2", int'(o_direction), 8);
    wait_n(4);
    chk("clr_noreplay", int'(o_queue_count), 0);
    load_up_left();
    chk("rst_pre_cnt", int'(o_queue_count), 2);
    pulse_reset();
    chk("rst_cnt", int'(o_queue_count), 0);
    chk("rst_dir", int'(o_direction), 8);
    wait_n(5);
    chk("rst_left_rejected", int'(o_queue_count), 0);

    // Invalid codes
    i_mapped_key = 8'h05; wait_n(4);
    i_mapped_key = 8'hF0; wait_n(4);
    chk("inv_cnt", int'(o_queue_count), 0);
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      chk("inv_dir", int'(o_direction), 8);
      chk("inv_turned", int'(o_turned), 0);
    end

    // Random soak
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        i_mapped_key = keys[$urandom_range(0, 7)];
        hold = $urandom_range(1, 6);
      end else begin
        hold--;
      end
      i_tick  = ($urandom_range(0, 3) == 0);
      i_clear = ($urandom_range(0, 149) == 0);
      i_reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    i_tick = 1'b0; i_clear = 1'b0; i_reset = 1'b0;
    wait_n(10);
    chk("turn_q_drained", turn_q.size(), 0);
    chk("drop_q_drained", drop_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/direction_queue.md
# direction_queue

Downstream consumer of the PS/2 keyboard decoder's `mapped_key` bus. Synchronises the key code into the game clock domain, turns key changes into one-shot direction requests, filters illegal turns (repeat or 180° reversal) and buffers up to DEPTH pending turns. On each game `tick` it applies at most one pending turn, so the snake movement logic reads a clean, legal one-hot `direction`.

## Interface
- `DEPTH`, 2: pending-turn queue depth, legal range 1..4.
- `INIT_DIR`, 4'b1000: direction loaded on reset and on `clear` (RIGHT).
- `clock`  in  1  game clock, rising edge; the only clock in the block.
- `reset`  in  1  synchronous, active-high; clears all state on the rising edge of `clock`.
- `mapped_key`  in  8  keyboard decoder output, asynchronous to `clock`. UP=8'h01, DOWN=8'h02, LEFT=8'h04, RIGHT=8'h08, none=8'h00. Bits [7:4] are ignored.
- `tick`  in  1  one-cycle pulse when the snake advances one cell.
- `clear`  in  1  synchronous flush for a new game.
- `direction`  out  4  current one-hot direction.
- `turned`  out  1  one-cycle pulse when `direction` changes.
- `dropped`  out  1  one-cycle pulse when a legal request is discarded because the queue is full.
- `queue_count`  out  3  number of pending entries, 0..DEPTH.

## Operation
- **Synchroniser:** two flops (`s1`, `s2`) on `mapped_key[3:0]`, plus a history flop `s3` that holds the previous `s2`.
- **Event:** an event occurs in a cycle when `s2 != s3` and `s2` is exactly one-hot.
  - Zero or multi-bit values never generate an event, but they do update `s3`.
  - Because a release produces a transition to zero, pressing the same key twice yields two events.
- **Reference direction for filtering:** the queue tail if the queue is non-empty, otherwise `direction`. The reference is always sampled from pre-edge state.
- **Opposite of a one-hot d:** {d[2],d[3],d[0],d[1]}.
- **Reject** the event (no state change, no `dropped` pulse) if the candidate equals the reference or equals the opposite of the reference.
- **Accept** the event: push the candidate to the queue tail if there is space. Space counts as available when `queue_count < DEPTH`, or when `queue_count == DEPTH` and `tick` pops in the same cycle.
- **Full:** if there is no space, discard the candidate and pulse `dropped`.
- **Tick with non-empty queue:** pop the head into `direction` and pulse `turned`. The head is legal by construction.
- **Tick with empty queue:** `direction` holds and `turned` stays 0.
- **Tick and accepted event in the same cycle:**
  - Pop and push both occur.
  - `queue_count` is unchanged if the queue was non-empty.
  - If the queue was empty, `queue_count` becomes 1; the new entry is not applied on this tick.
- **Queue storage:** circular buffer with read and write pointers that wrap modulo DEPTH; `queue_count` is tracked explicitly.
- **`clear`:**
  - Empties the queue, loads `INIT_DIR` and forces `turned` and `dropped` to 0.
  - Sets `s3` to the current `s2`, so a key already held is not replayed.
  - Has priority over `tick` and events in the same cycle.
- **`reset`:**
  - Same effect as `clear`, except `s1`, `s2` and `s3` are cleared to 0.
  - Resetting mid-operation discards all pending entries.

## Timing
- Reset values:
  - `direction` = INIT_DIR.
  - `turned` = 0, `dropped` = 0, `queue_count` = 0.
  - `s1`, `s2`, `s3` = 0.
- All outputs are registered; there are no combinational paths from input to output.
- **Key latency:** a `mapped_key` change meeting setup before edge E appears in `s2` at E+1. The event is evaluated in the cycle after E+1 and is enqueued at edge E+2 (`queue_count` updates at E+2).
- **Tick latency:** `tick` high in the cycle before edge T produces a `direction` update and a `turned` pulse at edge T, lasting exactly one cycle.
- **`dropped`:** asserted at the same edge as the rejected enqueue would have occurred, for one cycle.
- A `mapped_key` change shorter than one `clock` period may be missed; this is acceptable because PS/2 codes persist for milliseconds.

## Test plan
- **Reset and first turn:** reset, then `mapped_key`=8'h01, wait 4 cycles, pulse `tick`.
  - After reset: `direction`=4'b1000, `queue_count`=0.
  - After the key: `queue_count`=1.
  - After the tick: `direction`=4'b0001, `turned` pulses once, `queue_count`=0.
- **Reversal and repeat filtering:** with `direction`=RIGHT, apply LEFT (8'h04), then RIGHT via 8'h00 → 8'h08.
  - `queue_count` stays 0 and `dropped` stays 0.
  - A `tick` leaves `direction`=4'b1000 with no `turned` pulse.
- **Queue fill and overflow (DEPTH=2):** from RIGHT, apply UP, LEFT, DOWN with no `tick`.
  - `queue_count`=2 and `dropped` pulses once on DOWN.
  - Two ticks give `direction`=UP, then LEFT.
- **Simultaneous tick and enqueue while full:** queue=[UP, LEFT], `tick` coincides with an accepted DOWN event.
  - `direction`=UP and `queue_count` stays 2.
  - The next two ticks give LEFT, then DOWN.
- **Clear and reset mid-operation:** queue=[UP, LEFT] with `mapped_key` held at 8'h04.
  - `clear`: `queue_count`=0, `direction`=RIGHT, no event replayed.
  - A later `reset` gives the same outputs; the held LEFT is then re-detected (`s3` was 0) and rejected as the reversal of RIGHT.
- **Invalid codes:** apply `mapped_key`=8'h05 and 8'hF0.
  - No event is generated, `queue_count`=0 and `direction` is unchanged across 3 ticks.
